// File: rtl/mcu_sys_target_if.sv
// Byte-level link between the SPI MCU block and the system-control target.
// The SPI side presents one payload byte per strobe and collects the reply
// byte that it shifts out during the following transfer byte.
interface mcu_sys_target_if;
  logic       mcu_sys_strobe;  // one-clk pulse: payload byte valid
  logic       mcu_start;       // current byte is the first of the transfer
  logic [7:0] mcu_dout;        // payload byte from the MCU
  logic [7:0] mcu_sys_din;     // reply byte towards the MCU

  // SPI block side
  modport master (
    output mcu_sys_strobe,
    output mcu_start,
    output mcu_dout,
    input  mcu_sys_din
  );

  // System-control target side
  modport slave (
    input  mcu_sys_strobe,
    input  mcu_start,
    input  mcu_dout,
    output mcu_sys_din
  );
endinterface

// File: rtl/mcu_sys_target.sv
// System-control target (target id 0) behind the SPI MCU byte interface.
// Decodes version query, LED control, core reset control, config register
// writes and interrupt status readback. Replies are registered and appear
// on mcu_sys_din one clk after the strobe that produced them.
module mcu_sys_target #(
  parameter logic [7:0] VERSION  = 8'h01,
  parameter int         CFG_REGS = 8
) (
  input  logic                 clk,
  input  logic                 reset,       // asynchronous, active low
  mcu_sys_target_if.slave      bus,
  output logic [1:0]           leds,
  output logic                 core_reset,
  output logic                 cfg_we,
  output logic [3:0]           cfg_idx,
  output logic [7:0]           cfg_data,
  input  logic [7:0]           irq_in,
  output logic                 int_n
);

  localparam logic [7:0] CMD_GET_VERSION = 8'h00;
  localparam logic [7:0] CMD_SET_LEDS    = 8'h01;
  localparam logic [7:0] CMD_SET_RESET   = 8'h02;
  localparam logic [7:0] CMD_SET_CFG     = 8'h03;
  localparam logic [7:0] CMD_GET_INT     = 8'h04;

  // Register count widened by one bit so CFG_REGS=16 still compares correctly.
  localparam logic [4:0] CFG_LIMIT = 5'(CFG_REGS);

  typedef enum logic [2:0] {
    IDLE, VER1, VER2, LED, RST, CFG_IDX, CFG_VAL, DONE
  } state_t;

  state_t     state_reg;
  logic [3:0] idx_reg;        // register index latched between the two SET_CFG bytes
  logic [7:0] pending_reg;    // sticky interrupt flags
  logic [7:0] irq_prev_reg;   // irq_in one clk ago, for rising edge detection

  logic [7:0] rise;
  logic       get_int;
  logic [7:0] pending_next;

  // Rising edges this clk, and the GET_INT clear that drops older flags
  // while keeping any edge arriving on the same clk.
  always_comb begin
    rise         = irq_in & ~irq_prev_reg;
    get_int      = bus.mcu_sys_strobe && bus.mcu_start && (bus.mcu_dout == CMD_GET_INT);
    pending_next = (get_int ? 8'h00 : pending_reg) | rise;
  end

  // Interrupt edge history, pending flags and registered int_n.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_prev_reg <= 8'h00;
      pending_reg  <= 8'h00;
      int_n        <= 1'b1;
    end else begin
      irq_prev_reg <= irq_in;
      pending_reg  <= pending_next;
      int_n        <= ~|pending_next;
    end
  end

  // Command FSM with registered reply and control outputs. A start byte
  // always restarts decoding so an aborted transfer cannot leak forward.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      idx_reg         <= 4'h0;
      bus.mcu_sys_din <= 8'h00;
      leds            <= 2'b00;
      core_reset      <= 1'b1;
      cfg_we          <= 1'b0;
      cfg_idx         <= 4'h0;
      cfg_data        <= 8'h00;
    end else begin
      cfg_we <= 1'b0;
      if (bus.mcu_sys_strobe) begin
        if (bus.mcu_start) begin
          bus.mcu_sys_din <= 8'h00;
          case (bus.mcu_dout)
            CMD_GET_VERSION: begin
              bus.mcu_sys_din <= 8'h5C;
              state_reg       <= VER1;
            end
            CMD_SET_LEDS:  state_reg <= LED;
            CMD_SET_RESET: state_reg <= RST;
            CMD_SET_CFG:   state_reg <= CFG_IDX;
            CMD_GET_INT: begin
              bus.mcu_sys_din <= pending_reg;
              state_reg       <= DONE;
            end
            default:       state_reg <= DONE;
          endcase
        end else begin
          case (state_reg)
            IDLE: ;  // no transfer open: stray bytes are ignored entirely
            VER1: begin
              bus.mcu_sys_din <= 8'h42;
              state_reg       <= VER2;
            end
            VER2: begin
              bus.mcu_sys_din <= VERSION;
              state_reg       <= DONE;
            end
            LED: begin
              leds            <= bus.mcu_dout[1:0];
              bus.mcu_sys_din <= 8'h00;
              state_reg       <= DONE;
            end
            RST: begin
              core_reset      <= bus.mcu_dout[0];
              bus.mcu_sys_din <= 8'h00;
              state_reg       <= DONE;
            end
            CFG_IDX: begin
              idx_reg         <= bus.mcu_dout[3:0];
              bus.mcu_sys_din <= 8'h00;
              state_reg       <= CFG_VAL;
            end
            CFG_VAL: begin
              if ({1'b0, idx_reg} < CFG_LIMIT) begin
                cfg_we   <= 1'b1;
                cfg_idx  <= idx_reg;
                cfg_data <= bus.mcu_dout;
              end
              bus.mcu_sys_din <= 8'h00;
              state_reg       <= DONE;
            end
            DONE:    bus.mcu_sys_din <= 8'h00;
            default: state_reg <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_mcu_sys_target.sv
// Directed bench for mcu_sys_target: reply bytes go through a scoreboard
// queue, control outputs and interrupt behaviour are checked in place.
module tb_mcu_sys_target;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] leds;
  logic       core_reset;
  logic       cfg_we;
  logic [3:0] cfg_idx;
  logic [7:0] cfg_data;
  logic [7:0] irq_in;
  logic       int_n;

  int n_tests = 0;
  int n_fail  = 0;
  int we_cnt  = 0;
  int we_base;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  mcu_sys_target_if bus ();

  mcu_sys_target #(.VERSION(8'h01), .CFG_REGS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .leds       (leds),
    .core_reset (core_reset),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_data   (cfg_data),
    .irq_in     (irq_in),
    .int_n      (int_n)
  );

  always #5 clk = ~clk;

  // Count clks with cfg_we high, sampled away from the active edge.
  always @(negedge clk) if (cfg_we === 1'b1) we_cnt++;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // One byte strobe; returns on the negedge after the consuming posedge.
  task automatic strobe(input logic start, input logic [7:0] data);
    @(negedge clk);
    bus.mcu_sys_strobe = 1'b1;
    bus.mcu_start      = start;
    bus.mcu_dout       = data;
    @(negedge clk);
    bus.mcu_sys_strobe = 1'b0;
    bus.mcu_start      = 1'b0;
    $display("[TB] strobe start=%0b byte=%02h -> din=%02h leds=%0b core_reset=%0b int_n=%0b",
             start, data, bus.mcu_sys_din, leds, core_reset, int_n);
  endtask

  // Strobe a byte whose reply is predicted by the scoreboard.
  task automatic send_exp(input logic start, input logic [7:0] data,
                          input logic [7:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    strobe(start, data);
    check(tag_q.pop_front(), bus.mcu_sys_din, exp_q.pop_front());
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_din"},        bus.mcu_sys_din, 8'h00);
    check({pfx, "_leds"},       {6'd0, leds}, 8'h00);
    check({pfx, "_core_reset"}, {7'd0, core_reset}, 8'h01);
    check({pfx, "_cfg_we"},     {7'd0, cfg_we}, 8'h00);
    check({pfx, "_cfg_idx"},    {4'd0, cfg_idx}, 8'h00);
    check({pfx, "_cfg_data"},   cfg_data, 8'h00);
    check({pfx, "_int_n"},      {7'd0, int_n}, 8'h01);
  endtask

  initial begin
    reset              = 1'b0;
    irq_in             = 8'h00;
    bus.mcu_sys_strobe = 1'b0;
    bus.mcu_start      = 1'b0;
    bus.mcu_dout       = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b1;

    // Stray non-start byte in IDLE: nothing changes
    send_exp(1'b0, 8'h01, 8'h00, "idle_stray_din");
    check("idle_stray_leds", {6'd0, leds}, 8'h00);

    // GET_VERSION
    send_exp(1'b1, 8'h00, 8'h5C, "ver_magic0");
    send_exp(1'b0, 8'hFF, 8'h42, "ver_magic1");
    send_exp(1'b0, 8'hFF, 8'h01, "ver_version");
    send_exp(1'b0, 8'hFF, 8'h00, "ver_done");

    // SET_LEDS and SET_RESET
    send_exp(1'b1, 8'h01, 8'h00, "leds_cmd");
    strobe(1'b0, 8'h03);
    check("leds_val", {6'd0, leds}, 8'h03);
    send_exp(1'b1, 8'h02, 8'h00, "rst_cmd");
    strobe(1'b0, 8'h00);
    check("core_reset_val", {7'd0, core_reset}, 8'h00);

    // SET_CFG in range: exactly one write pulse
    we_base = we_cnt;
    strobe(1'b1, 8'h03);
    strobe(1'b0, 8'h05);
    strobe(1'b0, 8'hA7);
    check("cfg_we_high", {7'd0, cfg_we}, 8'h01);
    check("cfg_idx", {4'd0, cfg_idx}, 8'h05);
    check("cfg_data", cfg_data, 8'hA7);
    repeat (3) @(negedge clk);
    check("cfg_we_pulses", 8'(we_cnt - we_base), 8'h01);

    // SET_CFG out of range: no pulse, outputs hold
    we_base = we_cnt;
    strobe(1'b1, 8'h03);
    strobe(1'b0, 8'h0C);
    strobe(1'b0, 8'h55);
    repeat (3) @(negedge clk);
    check("cfg_oob_pulses", 8'(we_cnt - we_base), 8'h00);
    check("cfg_oob_idx_hold", {4'd0, cfg_idx}, 8'h05);
    check("cfg_oob_data_hold", cfg_data, 8'hA7);

    // Interrupt on bit2 rising
    check("int_idle", {7'd0, int_n}, 8'h01);
    @(negedge clk);
    irq_in[2] = 1'b1;
    @(negedge clk);
    check("int_bit2_low", {7'd0, int_n}, 8'h00);
    send_exp(1'b1, 8'h04, 8'h04, "getint_bit2");
    check("int_cleared", {7'd0, int_n}, 8'h01);
    repeat (4) @(negedge clk);
    check("int_held_level", {7'd0, int_n}, 8'h01);
    irq_in[2] = 1'b0;
    repeat (2) @(negedge clk);
    check("int_fall_quiet", {7'd0, int_n}, 8'h01);
    irq_in[2] = 1'b1;
    @(negedge clk);
    check("int_rerise_low", {7'd0, int_n}, 8'h00);
    send_exp(1'b1, 8'h04, 8'h04, "getint_rerise");

    // Bit5 rises on the exact clk of the GET_INT strobe
    @(negedge clk);
    bus.mcu_sys_strobe = 1'b1;
    bus.mcu_start      = 1'b1;
    bus.mcu_dout       = 8'h04;
    irq_in[5]          = 1'b1;
    exp_q.push_back(8'h00);
    tag_q.push_back("getint_race_din");
    @(negedge clk);
    bus.mcu_sys_strobe = 1'b0;
    bus.mcu_start      = 1'b0;
    $display("[TB] strobe start=1 byte=04 with irq bit5 rise -> din=%02h int_n=%0b",
             bus.mcu_sys_din, int_n);
    check(tag_q.pop_front(), bus.mcu_sys_din, exp_q.pop_front());
    check("getint_race_int", {7'd0, int_n}, 8'h00);
    send_exp(1'b1, 8'h04, 8'h20, "getint_bit5_kept");
    check("int_after_bit5", {7'd0, int_n}, 8'h01);

    // Reset in the middle of SET_CFG
    irq_in = 8'h00;
    repeat (2) @(negedge clk);
    we_base = we_cnt;
    strobe(1'b1, 8'h03);
    strobe(1'b0, 8'h02);
    reset = 1'b0;
    #1;
    check_reset_values("midrst");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    strobe(1'b0, 8'h99);
    repeat (2) @(negedge clk);
    check("midrst_no_write", 8'(we_cnt - we_base), 8'h00);
    send_exp(1'b1, 8'h00, 8'h5C, "post_rst_ver");

    check("scoreboard_empty", 8'(exp_q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mcu_sys_target.md
Name: mcu_sys_target

Overview:
- Downstream consumer of the SPI MCU byte interface, on the system-control target (target id 0).
- Decodes MCU commands carried in the byte stream: version query, LED control, core reset control, config register writes and interrupt status readback.
- Returns reply bytes on mcu_sys_din, which the SPI block shifts out during the following byte.

Parameters:
- VERSION, 8'h01, core version byte returned by GET_VERSION.
- CFG_REGS, 8, number of 8-bit config registers (1..16); index width is 4 bits.

Ports:
- clk  input  1  system clock; same clock as the SPI byte interface.
- reset  input  1  asynchronous, active-low reset.
- mcu_sys_strobe  input  1  one-clk pulse; a payload byte for target 0 is valid on mcu_dout.
- mcu_start  input  1  high while the current payload byte is the first of the transfer.
- mcu_dout  input  8  payload byte from the MCU.
- mcu_sys_din  output  8  reply byte towards the MCU.
- leds  output  2  board LEDs.
- core_reset  output  1  reset request to the emulated core.
- cfg_we  output  1  one-clk pulse when a config register is written.
- cfg_idx  output  4  index of the written register.
- cfg_data  output  8  value of the written register.
- irq_in  input  8  interrupt sources from the core, level, synchronous to clk.
- int_n  output  1  interrupt line to the MCU, active low.

Behaviour:
- Reset (reset=0, async): all outputs to these values.
  - mcu_sys_din=8'h00, leds=0, core_reset=1, cfg_we=0, cfg_idx=0, cfg_data=0, int_n=1.
  - Pending register and irq_in history register cleared.
  - FSM to IDLE.
- Byte acceptance: a byte is consumed only on a clk where mcu_sys_strobe=1. If mcu_start=1 on that clk, the byte is a command and the FSM restarts from IDLE, whatever its current state, so an aborted transfer never leaks into the next one.
- Reply timing: mcu_sys_din is registered and updates on the clk after the strobe. It holds until the next strobe.
- Commands (FSM: IDLE, VER1, VER2, LED, RST, CFG_IDX, CFG_VAL, DONE):
  - 8'h00 GET_VERSION: mcu_sys_din<=8'h5C, go to VER1. Next strobe: din<=8'h42, go to VER2. Next strobe: din<=VERSION, go to DONE.
  - 8'h01 SET_LEDS: go to LED. Next strobe: leds<=byte[1:0], go to DONE.
  - 8'h02 SET_RESET: go to RST. Next strobe: core_reset<=byte[0], go to DONE.
  - 8'h03 SET_CFG: go to CFG_IDX. Next strobe: latch index=byte[3:0], go to CFG_VAL.
    - Following strobe: if index<CFG_REGS, pulse cfg_we for exactly one clk with cfg_idx/cfg_data. Otherwise no pulse.
    - Then go to DONE.
  - 8'h04 GET_INT: on the command strobe, mcu_sys_din<=pending, then go to DONE.
    - On the same clk, pending<=rising edges detected this clk only; all prior pending bits are cleared.
  - Any other command: go to DONE, din<=8'h00.
- DONE: further non-start bytes are ignored. mcu_sys_din<=8'h00 on each such strobe.
- Interrupts:
  - Edge detection: irq_prev<=irq_in every clk. rise=irq_in&~irq_prev.
  - pending<=pending|rise.
  - int_n is registered: int_n<=~|(next pending). It goes low one clk after the rising edge.
  - A rise coinciding with a GET_INT clear remains pending and is not lost.
- cfg_we is deasserted in every clk except the single write clk. cfg_idx and cfg_data hold their last values.
- Reset mid-command: async reset returns the FSM to IDLE immediately. Partial SET_CFG produces no write.

Test Plan:
- Reset release, then strobe 8'h00 with start=1, then two strobes with 8'hFF -> din reads 5C, 42, then VERSION=01, each one clk after its strobe; a fourth strobe gives 00.
- Command 8'h01 then byte 8'h03 -> leds=2'b11; command 8'h02 then 8'h00 -> core_reset=0; strobes with start=0 while in IDLE, before any command, have no effect.
- Command 8'h03, idx 8'h05, value 8'hA7 -> cfg_we high for exactly 1 clk with cfg_idx=5, cfg_data=A7. Repeat with idx 8'h0C (CFG_REGS=8) -> no cfg_we pulse.
- irq_in bit2 rises -> int_n=0 one clk later. GET_INT command -> din=8'h04, int_n=1 afterwards. Bit2 held high -> no new interrupt until it falls and rises again.
- irq_in bit5 rises on the exact clk of the GET_INT strobe -> din reflects only prior bits (bit5 clear); bit5 stays pending and int_n stays 0.
- Send 8'h03, 8'h02, then assert reset=0 before the value byte -> no cfg_we, all outputs at reset values. A new start byte 8'h00 after release -> din=5C.
